// File: rtl/count_chk_pkg.sv
// Shared types and constants for the count sequence checker.
package count_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int unsigned RUN_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment on the clear edge yields 1.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && count != MAX) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// Checks that a sampled count stream advances by exactly one (mod 2^WIDTH) per accepted sample.
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned ERR_W      = 8,
    parameter bit          ALLOW_HOLD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_val
);

    state_t           state;
    logic [RUN_W-1:0] run;
    logic [WIDTH-1:0] expected;
    logic             match;
    logic             hold;
    logic             err_hit;

    assign expected = last_val + WIDTH'(1);
    assign match    = (cnt_in == expected);
    assign hold     = ALLOW_HOLD && (cnt_in == last_val);
    assign err_hit  = en && (state == LOCKED) && !match && !hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            run       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            last_val  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (en) begin
                // Always re-synchronise to the newest sample, even on a mismatch.
                last_val <= cnt_in;
                case (state)
                    IDLE: begin
                        run    <= '0;
                        state  <= SYNC;
                        locked <= 1'b0;
                    end
                    SYNC: begin
                        if (hold) begin
                            run <= run;
                        end else if (match) begin
                            if (run + RUN_W'(1) == RUN_W'(LOCK_CNT)) begin
                                run    <= '0;
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                run <= run + RUN_W'(1);
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!match && !hold) begin
                            err_pulse <= 1'b1;
                            run       <= '0;
                            state     <= SYNC;
                            locked    <= 1'b0;
                        end
                    end
                    default: begin
                        run    <= '0;
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_hit),
        .clr   (clr),
        .count (err_count)
    );

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: vector table, directed corner cases and a random model run.
module tb_count_seq_checker;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] cnt_in;

    logic       lk0, pl0, lk1, pl1;
    logic [7:0] ec0, ec1;
    logic [3:0] lv0, lv1;

    int nerr = 0;
    int nchk = 0;

    count_seq_checker #(
        .WIDTH (4), .LOCK_CNT (3), .ERR_W (8), .ALLOW_HOLD (1'b0)
    ) dut0 (
        .clk (clk), .rst (rst), .en (en), .cnt_in (cnt_in), .clr (clr),
        .locked (lk0), .err_pulse (pl0), .err_count (ec0), .last_val (lv0)
    );

    count_seq_checker #(
        .WIDTH (4), .LOCK_CNT (3), .ERR_W (8), .ALLOW_HOLD (1'b1)
    ) dut1 (
        .clk (clk), .rst (rst), .en (en), .cnt_in (cnt_in), .clr (clr),
        .locked (lk1), .err_pulse (pl1), .err_count (ec1), .last_val (lv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, index 0 = hold is an error, index 1 = hold is a stall.
    int m_started[2];
    int m_streak[2];
    int m_locked[2];
    int m_last[2];
    int m_errs[2];
    int m_pulse[2];

    task automatic m_reset();
        for (int h = 0; h < 2; h++) begin
            m_started[h] = 0; m_streak[h] = 0; m_locked[h] = 0;
            m_last[h] = 0; m_errs[h] = 0; m_pulse[h] = 0;
        end
    endtask

    task automatic m_step(input int e, input int c, input int v);
        for (int h = 0; h < 2; h++) begin
            m_pulse[h] = 0;
            if (c != 0) m_errs[h] = 0;
            if (e != 0) begin
                if (m_started[h] == 0) begin
                    m_started[h] = 1;
                    m_streak[h]  = 0;
                end else if (h == 1 && v == m_last[h]) begin
                    // stall: nothing advances
                end else if (v == (m_last[h] + 1) % 16) begin
                    if (m_locked[h] == 0) begin
                        m_streak[h]++;
                        if (m_streak[h] == 3) begin
                            m_locked[h] = 1;
                            m_streak[h] = 0;
                        end
                    end
                end else begin
                    if (m_locked[h] != 0) begin
                        m_pulse[h] = 1;
                        if (m_errs[h] < 255) m_errs[h]++;
                    end
                    m_locked[h] = 0;
                    m_streak[h] = 0;
                end
                m_last[h] = v;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int pack(input int l, input int p, input int e, input int v);
        return (l << 14) | (p << 13) | (e << 4) | v;
    endfunction

    task automatic chk_model(input string nm);
        chk({nm, "/hold0"}, pack(int'(lk0), int'(pl0), int'(ec0), int'(lv0)),
            pack(m_locked[0], m_pulse[0], m_errs[0], m_last[0]));
        chk({nm, "/hold1"}, pack(int'(lk1), int'(pl1), int'(ec1), int'(lv1)),
            pack(m_locked[1], m_pulse[1], m_errs[1], m_last[1]));
    endtask

    // Drive one edge, advance the model, then sample 1 ns after the edge.
    task automatic tick(input int e, input int c, input int v);
        en     = (e != 0);
        clr    = (c != 0);
        cnt_in = 4'(v);
        @(posedge clk);
        m_step(e, c, v % 16);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #20;
        m_reset();
        rst = 1'b1;
    endtask

    typedef struct {
        int en; int clr; int cnt;
        int lk; int pl; int ec; int lv;
    } vec_t;

    function automatic vec_t mk(input int e, input int c, input int v,
                                input int l, input int p, input int ec, input int lv);
        vec_t r;
        r.en = e; r.clr = c; r.cnt = v; r.lk = l; r.pl = p; r.ec = ec; r.lv = lv;
        return r;
    endfunction

    vec_t tbl[17];

    initial begin
        int v;
        int r;
        en = 1'b0; clr = 1'b0; cnt_in = 4'd0;
        tbl[0]  = mk(1, 0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1,  0, 0, 0, 1);
        tbl[2]  = mk(1, 0, 2,  0, 0, 0, 2);
        tbl[3]  = mk(1, 0, 3,  1, 0, 0, 3);
        tbl[4]  = mk(1, 0, 4,  1, 0, 0, 4);
        tbl[5]  = mk(1, 0, 5,  1, 0, 0, 5);
        tbl[6]  = mk(1, 0, 6,  1, 0, 0, 6);
        tbl[7]  = mk(1, 0, 9,  0, 1, 1, 9);
        tbl[8]  = mk(1, 0, 10, 0, 0, 1, 10);
        tbl[9]  = mk(1, 0, 11, 0, 0, 1, 11);
        tbl[10] = mk(1, 0, 12, 1, 0, 1, 12);
        tbl[11] = mk(1, 0, 13, 1, 0, 1, 13);
        tbl[12] = mk(1, 0, 14, 1, 0, 1, 14);
        tbl[13] = mk(1, 0, 15, 1, 0, 1, 15);
        tbl[14] = mk(1, 0, 0,  1, 0, 1, 0);
        tbl[15] = mk(1, 0, 1,  1, 0, 1, 1);
        tbl[16] = mk(0, 1, 7,  1, 0, 0, 1);

        do_reset();
        chk("reset_state", pack(int'(lk0), int'(pl0), int'(ec0), int'(lv0)), 0);

        // Lock, wrap, single error and relock, then clear while idle.
        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].en, tbl[i].clr, tbl[i].cnt);
            chk($sformatf("table[%0d]/hold0", i),
                pack(int'(lk0), int'(pl0), int'(ec0), int'(lv0)),
                pack(tbl[i].lk, tbl[i].pl, tbl[i].ec, tbl[i].lv));
            chk($sformatf("table[%0d]/hold1", i),
                pack(int'(lk1), int'(pl1), int'(ec1), int'(lv1)),
                pack(tbl[i].lk, tbl[i].pl, tbl[i].ec, tbl[i].lv));
        end

        // en low freezes everything; then the next count keeps lock.
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, int'($urandom_range(0, 15)));
            chk_model($sformatf("en_low[%0d]", i));
        end
        tick(1, 0, m_last[0] + 1);
        chk("en_resume_locked", int'(lk0), 1);
        chk_model("en_resume");

        // Hold: error with ALLOW_HOLD=0, stall with ALLOW_HOLD=1.
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 0, i);
        tick(1, 0, 3);
        chk("hold_err_h0", pack(int'(lk0), int'(pl0), int'(ec0), int'(lv0)), pack(0, 1, 1, 3));
        chk("hold_ok_h1", pack(int'(lk1), int'(pl1), int'(ec1), int'(lv1)), pack(1, 0, 0, 3));
        tick(1, 0, 4);
        chk("hold_next_h0", pack(int'(lk0), int'(pl0), int'(ec0), int'(lv0)), pack(0, 0, 1, 4));
        chk("hold_next_h1", pack(int'(lk1), int'(pl1), int'(ec1), int'(lv1)), pack(1, 0, 0, 4));

        // Error beats clear on the same edge.
        tick(1, 0, 5);
        tick(1, 0, 6);
        tick(1, 0, 7);
        tick(1, 1, 12);
        chk("clr_vs_err", int'(ec0), 1);
        chk("clr_vs_err_pulse", int'(pl0), 1);
        chk_model("clr_vs_err");

        // Saturation after 300 locked errors.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 3; k++) tick(1, 0, m_last[0] + 1);
            tick(1, 0, m_last[0] + 2);
        end
        chk("saturate", int'(ec0), 255);
        chk_model("saturate");

        // Asynchronous reset between edges.
        rst = 1'b0;
        #2;
        chk("async_rst_h0", pack(int'(lk0), int'(pl0), int'(ec0), int'(lv0)), 0);
        chk("async_rst_h1", pack(int'(lk1), int'(pl1), int'(ec1), int'(lv1)), 0);
        #2;
        m_reset();
        rst = 1'b1;

        // Random stream against the model.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)      v = m_last[0] + 1;
            else if (r < 8) v = m_last[0];
            else            v = int'($urandom_range(0, 15));
            tick(($urandom_range(0, 9) != 0) ? 1 : 0,
                 ($urandom_range(0, 29) == 0) ? 1 : 0, v % 16);
            chk_model($sformatf("random[%0d]", i));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive-side companion to the free-running up-counter. It samples a WIDTH-bit count stream and checks that each sample is the previous one plus 1, modulo 2^WIDTH.
- Reports lock status, a one-cycle error pulse and a saturating error tally.
- Sits beside any counter instance, in testbenches or on-chip self-check, consuming the counter's cnt output.

Parameters:
- WIDTH, 4, bit width of the checked count.
- LOCK_CNT, 3, consecutive correct increments required to declare lock (range 1..15).
- ERR_W, 8, width of the error tally.
- ALLOW_HOLD, 0, when 1 a sample equal to the previous one is a legal stall rather than a mismatch.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sample strobe; cnt_in is evaluated only on edges where en=1.
- cnt_in  in  WIDTH  count value under check.
- clr  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse on a mismatch while LOCKED.
- err_count  out  ERR_W  saturating count of errors.
- last_val  out  WIDTH  most recently accepted sample.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, run=0.
  - locked=0, err_pulse=0, err_count=0, last_val=0.
  - Takes effect immediately mid-operation, with no waiting for clk.
- All outputs are registered. A sample captured at edge N is reflected in the outputs after edge N. Latency is 1 clock.
- expected = last_val + 1, truncated to WIDTH bits, so all-ones wraps to 0.
- State machine, evaluated only on edges with en=1:
  - IDLE: accept sample, last_val<=cnt_in, run<=0, go to SYNC. No error.
  - SYNC, match: run<=run+1. If run+1==LOCK_CNT, go to LOCKED and run<=0.
  - SYNC, mismatch: run<=0, stay in SYNC, no error, no tally.
  - LOCKED, match: stay in LOCKED.
  - LOCKED, mismatch: err_pulse<=1 for exactly one cycle, err_count increments, go to SYNC with run=0.
  - last_val<=cnt_in on every accepted sample in every state, including mismatches (re-synchronise to the new value).
- Hold (cnt_in==last_val):
  - ALLOW_HOLD=1: no state change and no run advance.
  - ALLOW_HOLD=0: treated as a mismatch.
- en=0: state, run and last_val are frozen. err_pulse<=0. clr still acts.
- err_count:
  - Saturates at 2^ERR_W-1 and never wraps.
  - clr=1 sets it to 0.
  - clr together with an error on the same edge gives err_count=1, because the error wins over the clear.
- err_pulse is never high on two consecutive cycles. A mismatch on the next sample occurs in SYNC, so it does not tally.
- locked = (state==LOCKED), registered.

Decomposition:
- Package count_chk_pkg:
  - state encoding constants: IDLE=2'd0, SYNC=2'd1, LOCKED=2'd2.
  - LOCK_CNT run-counter width (4 bits).
- One natural sub-module, sat_counter, parameterised by width, with inc and clr inputs and clear/increment priority as specified above. It is used for err_count.
- The FSM and compare logic stay in the top module.

Test Plan:
1. rst low 20 ns then high; en=1; cnt_in 0,1,2,3 on consecutive edges -> locked=1 after the 4th edge, err_pulse never high, err_count=0, last_val=3.
2. Locked; cnt_in 14,15,0,1 -> no err_pulse, locked stays 1 across the 15->0 wrap.
3. Locked at 6; cnt_in 9 -> err_pulse high exactly one cycle, err_count=1, locked=0, last_val=9. Then cnt_in 10,11,12 -> locked=1 again, err_count still 1.
4. en=0 for 5 cycles with random cnt_in -> locked, last_val and err_count unchanged, err_pulse=0. Then en=1 with last_val+1 -> still locked.
5. ALLOW_HOLD=0, locked at 3, cnt_in 3 -> error, err_count+1. ALLOW_HOLD=1, same stimulus -> no error, still locked; then 4 accepted.
6. clr on the same edge as a locked mismatch -> err_count=1. Force 300 locked-state errors with ERR_W=8 -> err_count=255. Drive rst low mid-stream between edges -> all outputs 0 immediately.
